// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: unpacks host words LSB-first onto ccff_head with a
// per-bit shift enable, and packs the bits leaving ccff_tail back into readback words.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 18,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN+1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              m_valid,
  output logic [WORD_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  localparam int LW = $clog2(WORD_W+1);
  localparam int IW = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] ALL_BITS  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN-1);
  localparam logic [LW-1:0]    FULL_WORD = LW'(WORD_W);
  localparam logic [LW-1:0]    TOP_IDX   = LW'(WORD_W-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;

  logic [CNT_W-1:0]  cnt, acc_bits, rb_cnt;
  logic              pf_full;
  logic [WORD_W-1:0] pf_data, up_data;
  logic [LW-1:0]     pf_len, up_cnt, word_len;
  logic [31:0]       rem_bits;

  logic [WORD_W-1:0] col_data, col_data_n;
  logic [LW-1:0]     col_cnt, col_cnt_n;
  logic              col_closed, col_closed_n, col_last, col_last_n, m_last;

  logic start_pass, accept, move, blocked, shift_now, up_load, fin_accept;

  // Input side: prefetch refills the unpack register on the same edge its last bit leaves,
  // so word boundaries cost no shift bubble.
  always_comb begin
    rem_bits  = 32'(CHAIN_LEN) - 32'(acc_bits);
    word_len  = (rem_bits >= 32'(WORD_W)) ? FULL_WORD : LW'(rem_bits);
    accept    = s_valid & s_ready;
    shift_now = (state == RUN) & (up_cnt != '0) & ~blocked;
    up_load   = pf_full & ((up_cnt == '0) | (shift_now & (up_cnt == LW'(1))));
  end

  // Readback side. The bit captured next edge was issued last edge, so blocking looks one
  // edge ahead: stall when the collector will be closed and the output register still held.
  always_comb begin
    move         = col_closed & (~m_valid | m_ready);
    col_data_n   = col_data;
    col_cnt_n    = col_cnt;
    col_closed_n = col_closed;
    col_last_n   = col_last;
    if (move) begin
      col_data_n   = '0;
      col_cnt_n    = '0;
      col_closed_n = 1'b0;
      col_last_n   = 1'b0;
    end
    if (ccff_shift_en) begin
      col_data_n[col_cnt_n[IW-1:0]] = ccff_tail;
      if ((col_cnt_n == TOP_IDX) || (rb_cnt == LAST_BIT)) col_closed_n = 1'b1;
      if (rb_cnt == LAST_BIT) col_last_n = 1'b1;
      col_cnt_n = col_cnt_n + LW'(1);
    end
    blocked = col_closed_n & (move | (m_valid & ~m_ready));
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    start_pass = 1'b0;
    fin_accept = 1'b0;
    busy       = (state != IDLE);
    s_ready    = (state == RUN) & ~pf_full & (acc_bits != ALL_BITS);
    case (state)
      IDLE: begin
        start_pass = start;
        if (start) state_n = RUN;
      end
      RUN:   if (shift_now && (cnt == LAST_BIT)) state_n = DRAIN;
      DRAIN: begin
        fin_accept = m_valid & m_ready & m_last;
        if (fin_accept) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      cnt           <= '0;
      acc_bits      <= '0;
      rb_cnt        <= '0;
      pf_full       <= 1'b0;
      pf_data       <= '0;
      pf_len        <= '0;
      up_data       <= '0;
      up_cnt        <= '0;
      col_data      <= '0;
      col_cnt       <= '0;
      col_closed    <= 1'b0;
      col_last      <= 1'b0;
      m_valid       <= 1'b0;
      m_data        <= '0;
      m_last        <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      done          <= 1'b0;
    end else if (start_pass) begin
      cnt           <= '0;
      acc_bits      <= '0;
      rb_cnt        <= '0;
      pf_full       <= 1'b0;
      pf_data       <= '0;
      pf_len        <= '0;
      up_data       <= '0;
      up_cnt        <= '0;
      col_data      <= '0;
      col_cnt       <= '0;
      col_closed    <= 1'b0;
      col_last      <= 1'b0;
      m_valid       <= 1'b0;
      m_data        <= '0;
      m_last        <= 1'b0;
      ccff_shift_en <= 1'b0;
      done          <= 1'b0;
    end else begin
      ccff_shift_en <= shift_now;
      if (shift_now) ccff_head <= up_data[0];
      if (shift_now && (cnt != ALL_BITS)) cnt <= cnt + CNT_W'(1);

      if (accept) begin
        pf_data  <= s_data;
        pf_len   <= word_len;
        pf_full  <= 1'b1;
        acc_bits <= acc_bits + CNT_W'(word_len);
      end else if (up_load) begin
        pf_full  <= 1'b0;
      end

      if (up_load) begin
        up_data <= pf_data;
        up_cnt  <= pf_len;
      end else if (shift_now) begin
        up_data <= up_data >> 1;
        up_cnt  <= up_cnt - LW'(1);
      end

      if (ccff_shift_en && (rb_cnt != ALL_BITS)) rb_cnt <= rb_cnt + CNT_W'(1);
      col_data   <= col_data_n;
      col_cnt    <= col_cnt_n;
      col_closed <= col_closed_n;
      col_last   <= col_last_n;

      if (move) begin
        m_data  <= col_data;
        m_valid <= 1'b1;
        m_last  <= col_last;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      if (fin_accept) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: table of load passes against an 18-bit DFF chain model,
// plus hand sequences for reset values, idle behaviour and an asynchronous mid-pass abort.
module tb_ccff_bitstream_loader;

  logic       prog_clk = 1'b0;
  logic       pReset, start, s_valid, s_ready, ccff_head, ccff_shift_en, ccff_tail;
  logic       m_valid, m_ready, busy, done;
  logic [7:0] s_data, m_data;
  logic [17:0] chain;
  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0]  w0, w1, w2;
    logic [17:0] head;   // bit i = i-th bit driven onto ccff_head
    logic [23:0] rb;     // {word2, word1, word0} expected readback
    int          gap;    // s_valid low cycles after the first handshake
    int          hold;   // m_ready low for cycles [0, hold)
    int          smid;   // cycle of an extra start pulse (0 = none)
    int          runs;   // expected number of ccff_shift_en bursts
    int          abort_at;
  } vec_t;
  vec_t vt [7];

  ccff_bitstream_loader #(.CHAIN_LEN(18), .WORD_W(8)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .done(done)
  );

  always #5 prog_clk = ~prog_clk;

  // Downstream chain: chain[0] is the head flop, chain[17] feeds ccff_tail.
  always @(posedge prog_clk or posedge pReset)
    if (pReset) chain <= '0;
    else if (ccff_shift_en) chain <= {chain[16:0], ccff_head};
  assign ccff_tail = chain[17];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_pass(input int p);
    vec_t v = vt[p];
    logic [7:0]  w [3];
    logic [17:0] got_head = '0;
    logic [17:0] exp_chain;
    logic [23:0] got_rb = '0;
    logic [7:0]  held_data = '0;
    logic        prev_se = 1'b0, held = 1'b0, fin = 1'b0;
    int widx = 0, gap_left = 0, nsh = 0, nrb = 0, nhs = 0, runs = 0;
    int first_hs = -1, first_sh = -1, last_sh = -1, last_rb = -1, stable_bad = 0;
    w[0] = v.w0; w[1] = v.w1; w[2] = v.w2;
    for (int k = 0; k < 300; k++) begin
      @(negedge prog_clk);
      start   = (k == 0) || (v.smid != 0 && k == v.smid);
      m_ready = (k >= v.hold);
      if (gap_left > 0) begin
        s_valid = 1'b0;
        gap_left--;
      end else begin
        s_valid = 1'b1;
        s_data  = (widx < 3) ? w[widx] : 8'hEE;
      end
      if (k == 0) check($sformatf("p%0d busy_pre", p), 32'(busy), 32'd0);
      if (k == 1) check($sformatf("p%0d busy_ready_done", p), 32'({busy, s_ready, done}), 32'b110);
      if (s_valid && s_ready) begin
        nhs++;
        if (first_hs < 0) first_hs = k;
        if (widx < 3) widx++;
        if (widx == 1 && nhs == 1) gap_left = v.gap;
      end
      if (ccff_shift_en) begin
        if (nsh < 18) got_head[nsh] = ccff_head;
        nsh++;
        last_sh = k;
        if (first_sh < 0) first_sh = k;
        if (!prev_se) runs++;
      end
      prev_se = ccff_shift_en;
      if (held && m_valid && (m_data !== held_data)) stable_bad++;
      held      = m_valid && !m_ready;
      held_data = m_data;
      if (m_valid && m_ready) begin
        if (nrb < 3) got_rb[8*nrb +: 8] = m_data;
        nrb++;
        last_rb = k;
      end
      if (v.hold > 0 && k == v.hold - 1)
        check($sformatf("p%0d stall_shifts", p), 32'(nsh), 32'd16);
      if (v.abort_at > 0 && k == v.abort_at) begin
        check($sformatf("p%0d pre_abort_shifts", p), 32'(nsh), 32'd10);
        return;
      end
      if (k > 1 && done) begin
        fin = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    start   = 1'b0;
    check($sformatf("p%0d finished", p), 32'(fin), 32'd1);
    check($sformatf("p%0d busy_end", p), 32'(busy), 32'd0);
    check($sformatf("p%0d handshakes", p), 32'(nhs), 32'd3);
    check($sformatf("p%0d shifts", p), 32'(nsh), 32'd18);
    check($sformatf("p%0d head", p), 32'(got_head), 32'(v.head));
    check($sformatf("p%0d runs", p), 32'(runs), 32'(v.runs));
    // sample index of handshake +3 = two edges after the handshake edge
    check($sformatf("p%0d first_shift_lat", p), 32'(first_sh - first_hs), 32'd3);
    check($sformatf("p%0d last_mvalid_lat", p), 32'(last_rb - last_sh), 32'd2);
    check($sformatf("p%0d rb_words", p), 32'(nrb), 32'd3);
    check($sformatf("p%0d rb_data", p), 32'(got_rb), 32'(v.rb));
    check($sformatf("p%0d mdata_stable", p), 32'(stable_bad), 32'd0);
    for (int i = 0; i < 18; i++) exp_chain[17-i] = v.head[i];
    check($sformatf("p%0d chain", p), 32'(chain), 32'(exp_chain));
  endtask

  initial begin
    int idle_bad = 0;
    pReset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

    vt[0] = '{w0: 8'hA5, w1: 8'h3C, w2: 8'h02, head: {2'b10, 8'h3C, 8'hA5}, rb: 24'h000000,
              gap: 0, hold: 0, smid: 0, runs: 1, abort_at: 0};
    vt[1] = '{w0: 8'hFF, w1: 8'hFF, w2: 8'h03, head: 18'h3FFFF, rb: 24'h023CA5,
              gap: 0, hold: 0, smid: 0, runs: 1, abort_at: 0};
    // starvation longer than one word's shift time leaves a visible bubble
    vt[2] = '{w0: 8'hA5, w1: 8'h3C, w2: 8'h02, head: {2'b10, 8'h3C, 8'hA5}, rb: 24'h03FFFF,
              gap: 12, hold: 0, smid: 0, runs: 2, abort_at: 0};
    // upper six bits of the last word must be discarded
    vt[3] = '{w0: 8'h5A, w1: 8'hC3, w2: 8'hF5, head: {2'b01, 8'hC3, 8'h5A}, rb: 24'h023CA5,
              gap: 0, hold: 24, smid: 0, runs: 2, abort_at: 0};
    vt[4] = '{w0: 8'hA5, w1: 8'h3C, w2: 8'h02, head: {2'b10, 8'h3C, 8'hA5}, rb: 24'h01C35A,
              gap: 0, hold: 0, smid: 10, runs: 1, abort_at: 0};
    vt[5] = '{w0: 8'hA5, w1: 8'h3C, w2: 8'h02, head: {2'b10, 8'h3C, 8'hA5}, rb: 24'h000000,
              gap: 0, hold: 0, smid: 0, runs: 1, abort_at: 13};
    vt[6] = '{w0: 8'h12, w1: 8'h34, w2: 8'hFE, head: {2'b10, 8'h34, 8'h12}, rb: 24'h000000,
              gap: 0, hold: 0, smid: 0, runs: 1, abort_at: 0};

    #3;
    check("rst_values", 32'({s_ready, ccff_head, ccff_shift_en, m_valid, m_data, busy, done}), 32'd0);
    repeat (2) @(negedge prog_clk);
    pReset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge prog_clk);
      if (ccff_shift_en || busy || s_ready || m_valid) idle_bad++;
    end
    check("idle_quiet", 32'(idle_bad), 32'd0);

    for (int p = 0; p < 7; p++) begin
      run_pass(p);
      if (vt[p].abort_at > 0) begin
        #2 pReset = 1'b1;
        #1 check("async_rst_values",
                 32'({s_ready, ccff_head, ccff_shift_en, m_valid, m_data, busy, done}), 32'd0);
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge prog_clk);
        pReset = 1'b0;
        repeat (2) @(negedge prog_clk);
        check("post_rst_idle", 32'({ccff_shift_en, busy, done}), 32'd0);
      end else begin
        m_ready = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
